// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for universal_shift_reg.
// The master side drives operation requests; the slave side (the register)
// returns contents, serial outputs and sequence status.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             clear;
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   modport master (
      output clear, en, mode, d, sin_l, sin_r, start, count,
      input  q, sout_l, sout_r, busy, done
   );

   modport slave (
      input  clear, en, mode, d, sin_l, sin_r, start, count,
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / load / shift / rotate / arithmetic shift
// as single steps, plus a counted multi-step sequence (IDLE/RUN FSM) that
// latches its mode and length at acceptance and pulses done when finished.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic reset_n,
   universal_shift_reg_if.slave bus
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_LOAD = 3'b001,
      M_SHL  = 3'b010,
      M_SHR  = 3'b011,
      M_ROL  = 3'b100,
      M_ROR  = 3'b101,
      M_ASR  = 3'b110,
      M_RSVD = 3'b111
   } mode_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e           state, state_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;
   mode_e            lmode, lmode_nxt;
   logic             done_r, done_nxt;
   mode_e            cur_mode;
   logic             seq_mode;

   // One step of the selected operation; reserved and hold leave v unchanged.
   function automatic logic [WIDTH-1:0] step_op(
      input mode_e            m,
      input logic [WIDTH-1:0] v,
      input logic [WIDTH-1:0] ld,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         M_LOAD: r = ld;
         M_SHL:  r = {v[WIDTH-2:0], sl};
         M_SHR:  r = {sr, v[WIDTH-1:1]};
         M_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         M_ROR:  r = {v[0], v[WIDTH-1:1]};
         M_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign cur_mode = mode_e'(bus.mode);

   // Only the shifting modes (SHL..ASR) may start a counted sequence.
   assign seq_mode = (bus.mode >= 3'b010) && (bus.mode <= 3'b110);

   // State, contents and sequence bookkeeping; async reset clears everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         q_r    <= '0;
         rem    <= '0;
         lmode  <= M_HOLD;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         q_r    <= q_nxt;
         rem    <= rem_nxt;
         lmode  <= lmode_nxt;
         done_r <= done_nxt;
      end
   end

   // Next-state logic: clear beats everything, en=0 freezes everything,
   // start beats a single step in IDLE, and RUN ignores start/mode inputs.
   always_comb begin
      state_nxt = state;
      q_nxt     = q_r;
      rem_nxt   = rem;
      lmode_nxt = lmode;
      done_nxt  = 1'b0;

      if (bus.clear) begin
         state_nxt = S_IDLE;
         q_nxt     = '0;
         rem_nxt   = '0;
      end else if (bus.en) begin
         case (state)
            S_IDLE: begin
               if (bus.start && seq_mode) begin
                  // Acceptance edge only latches; q moves on later edges.
                  lmode_nxt = cur_mode;
                  if (bus.count == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     state_nxt = S_RUN;
                     rem_nxt   = bus.count;
                  end
               end else begin
                  q_nxt = step_op(cur_mode, q_r, bus.d, bus.sin_l, bus.sin_r);
               end
            end
            S_RUN: begin
               // Serial inputs are sampled live on every step.
               q_nxt   = step_op(lmode, q_r, bus.d, bus.sin_l, bus.sin_r);
               rem_nxt = rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign bus.q      = q_r;
   assign bus.sout_l = q_r[WIDTH-1];
   assign bus.sout_r = q_r[0];
   assign bus.busy   = (state == S_RUN);
   assign bus.done   = done_r;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL provide parameter CNT_W, default 4, width of the shift-count input.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port clear  input  1  synchronous clear.
REQ-006 SHALL provide port en  input  1  operation enable.
REQ-007 SHALL provide port mode  input  3  operation select.
REQ-008 SHALL provide port d  input  WIDTH  parallel load data.
REQ-009 SHALL provide port sin_l  input  1  serial input entering bit 0 on a left shift.
REQ-010 SHALL provide port sin_r  input  1  serial input entering bit WIDTH-1 on a right shift.
REQ-011 SHALL provide port start  input  1  request for a multi-step shift sequence.
REQ-012 SHALL provide port count  input  CNT_W  number of steps in a sequence.
REQ-013 SHALL provide port q  output  WIDTH  register contents.
REQ-014 SHALL provide port sout_l  output  1  combinational copy of q[WIDTH-1].
REQ-015 SHALL provide port sout_r  output  1  combinational copy of q[0].
REQ-016 SHALL provide port busy  output  1  high while a sequence is running.
REQ-017 SHALL provide port done  output  1  one-cycle pulse marking the end of a sequence.

Function
REQ-018 SHALL decode mode as follows:
- 000: hold.
- 001: load d.
- 010: SHL, q <= {q[W-2:0], sin_l}.
- 011: SHR, q <= {sin_r, q[W-1:1]}.
- 100: ROL.
- 101: ROR.
- 110: ASR, which replicates the MSB and ignores sin_r.
- 111: reserved; behaves as hold.
REQ-019 SHALL, in state IDLE with en=1 and start=0, apply the selected mode exactly once per rising edge.
REQ-020 SHALL hold q unchanged whenever en=0, in any state.
REQ-021 SHALL implement exactly two states, IDLE and RUN; busy=1 if and only if the state is RUN.
REQ-022 SHALL accept start only when all of the following hold:
- the state is IDLE;
- en=1;
- mode is in 010..110.
When start is accepted, the acceptance edge latches mode and count, and q does not change on that edge.
REQ-023 SHALL, on accepting start with count>=1, enter RUN with remaining=count.
REQ-024 SHALL, in RUN, apply the latched mode on each edge with en=1 and decrement remaining; sin_l and sin_r are sampled live on each step.
REQ-025 SHALL, on the edge that makes remaining=0:
- return the state to IDLE;
- assert done for exactly the following cycle.
The resulting latency is count+1 edges from acceptance to done, plus any cycles with en=0.
REQ-026 SHALL, on accepting start with count=0, leave q unchanged, keep busy=0, and pulse done in the next cycle.
REQ-027 SHALL ignore start while in RUN; mode changes during RUN SHALL have no effect.
REQ-028 SHALL give start priority over single-step operation when both are possible in IDLE.
REQ-029 SHALL, when clear=1 at an edge, take priority over all other inputs and produce:
- q=0;
- state IDLE;
- busy=0 and done=0, with no done pulse generated for an aborted sequence.
REQ-030 SHALL register done, defaulting it to 0 on every edge that does not complete a sequence.

Reset
REQ-031 SHALL, while reset_n=0, immediately and independently of clk force:
- q=0;
- state IDLE;
- busy=0 and done=0;
- remaining=0.
REQ-032 SHALL, when reset is asserted mid-sequence, abort the sequence with no done pulse after release.
REQ-033 SHALL resume normal operation on the first rising edge after reset_n deasserts.

Verification (all scenarios with WIDTH=8)
REQ-034 SHALL cover: load 8'hA5 -> SHL with sin_l=1 -> q=8'h4B -> SHR with sin_r=0 -> q=8'h25, and sout_l/sout_r track q[7]/q[0].
REQ-035 SHALL cover: load 8'h81, start ROL with count=3 -> busy high for 3 cycles, q=8'h0C, done high for exactly 1 cycle.
REQ-036 SHALL cover: load 8'h80, start ASR with count=4, en=0 for 2 cycles mid-run -> q=8'hF8, done delayed by 2 cycles.
REQ-037 SHALL cover: start with count=0 -> q unchanged, busy never 1, done pulses 1 cycle after acceptance.
REQ-038 SHALL cover: clear=1 during RUN -> q=8'h00, busy=0, no done pulse; reset_n low mid-RUN between edges -> outputs 0 immediately.
